// File: rtl/serial_mag_comp_if.sv
// rtl/serial_mag_comp_if.sv - start/operand/result bundle for serial_mag_comp
//
// master: requester, drives start, a, b and observes busy, done, greater, less, equal
// slave : comparator, the reverse directions
interface serial_mag_comp_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             greater;
    logic             less;
    logic             equal;

    modport master (
        output start, a, b,
        input  busy, done, greater, less, equal
    );

    modport slave (
        input  start, a, b,
        output busy, done, greater, less, equal
    );
endinterface

// File: rtl/serial_mag_comp.sv
// rtl/serial_mag_comp.sv - bit-serial MSB-first magnitude comparator
//
// clk    : rising-edge clock
// rst_n  : asynchronous active-low reset
// bus    : slave side of serial_mag_comp_if
//          start/a/b in; busy, done (1-cycle pulse), greater/less/equal out
// WIDTH 2..64, SIGNED selects two's-complement, EARLY_EXIT stops at first
// differing bit (otherwise fixed WIDTH-cycle latency).
module serial_mag_comp #(
    parameter int WIDTH      = 8,
    parameter int SIGNED     = 0,
    parameter int EARLY_EXIT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_mag_comp_if.slave   bus
);
    localparam int              IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    typedef enum logic {IDLE, CMP} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;
    logic               eq_q, eq_d;
    // fixed-latency mode remembers the first difference and its polarity
    logic               sticky_q, sticky_d;
    logic               sticky_gt_q, sticky_gt_d;

    logic bit_a, bit_b, bit_diff, bit_gt, last_bit;
    logic fin, fin_gt, fin_lt, fin_eq;

    always_comb begin
        bit_a    = a_q[idx_q];
        bit_b    = b_q[idx_q];
        bit_diff = bit_a ^ bit_b;
        // the sign bit has inverted weight: a 1 there marks the smaller value
        bit_gt   = ((SIGNED != 0) && (idx_q == IDX_MSB)) ? bit_b : bit_a;
        last_bit = (idx_q == '0);
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        gt_d        = gt_q;
        lt_d        = lt_q;
        eq_d        = eq_q;
        sticky_d    = sticky_q;
        sticky_gt_d = sticky_gt_q;
        fin         = 1'b0;
        fin_gt      = 1'b0;
        fin_lt      = 1'b0;
        fin_eq      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d         = bus.a;
                    b_d         = bus.b;
                    idx_d       = IDX_MSB;
                    gt_d        = 1'b0;
                    lt_d        = 1'b0;
                    eq_d        = 1'b0;
                    sticky_d    = 1'b0;
                    sticky_gt_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = CMP;
                end
            end
            CMP: begin
                if (EARLY_EXIT != 0) begin
                    if (bit_diff) begin
                        fin    = 1'b1;
                        fin_gt = bit_gt;
                        fin_lt = ~bit_gt;
                    end else if (last_bit) begin
                        fin    = 1'b1;
                        fin_eq = 1'b1;
                    end
                end else begin
                    if (bit_diff && !sticky_q) begin
                        sticky_d    = 1'b1;
                        sticky_gt_d = bit_gt;
                    end
                    if (last_bit) begin
                        fin = 1'b1;
                        if (sticky_q) begin
                            fin_gt = sticky_gt_q;
                            fin_lt = ~sticky_gt_q;
                        end else if (bit_diff) begin
                            fin_gt = bit_gt;
                            fin_lt = ~bit_gt;
                        end else begin
                            fin_eq = 1'b1;
                        end
                    end
                end

                if (fin) begin
                    gt_d    = fin_gt;
                    lt_d    = fin_lt;
                    eq_d    = fin_eq;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = IDX_MSB;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= IDX_MSB;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            sticky_q    <= 1'b0;
            sticky_gt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            gt_q        <= gt_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
            sticky_q    <= sticky_d;
            sticky_gt_q <= sticky_gt_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.greater = gt_q;
    assign bus.less    = lt_q;
    assign bus.equal   = eq_q;
endmodule

// File: tb/tb_serial_mag_comp.sv
// tb/tb_serial_mag_comp.sv - directed bench for three serial_mag_comp variants
module tb_serial_mag_comp;
    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_LT = 3'b010;
    localparam logic [2:0] R_EQ = 3'b001;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         lat [3];
        logic [2:0] res [3];
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;

    int         checks = 0;
    int         errors = 0;
    int         cyc;
    int         lat [3];
    int         cnt [3];
    logic [2:0] res [3];

    always #5 clk = ~clk;

    // u: unsigned early-exit, s: signed early-exit, f: unsigned fixed latency
    serial_mag_comp_if #(.WIDTH(8)) bus_u ();
    serial_mag_comp_if #(.WIDTH(8)) bus_s ();
    serial_mag_comp_if #(.WIDTH(8)) bus_f ();

    assign bus_u.start = start;
    assign bus_u.a     = a;
    assign bus_u.b     = b;
    assign bus_s.start = start;
    assign bus_s.a     = a;
    assign bus_s.b     = b;
    assign bus_f.start = start;
    assign bus_f.a     = a;
    assign bus_f.b     = b;

    serial_mag_comp #(.WIDTH(8), .SIGNED(0), .EARLY_EXIT(1)) dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u));
    serial_mag_comp #(.WIDTH(8), .SIGNED(1), .EARLY_EXIT(1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
    serial_mag_comp #(.WIDTH(8), .SIGNED(0), .EARLY_EXIT(0)) dut_f (.clk(clk), .rst_n(rst_n), .bus(bus_f));

    task automatic clear_obs();
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0;
            cnt[i] = 0;
            res[i] = 3'b000;
        end
    endtask

    // advance one clock and record the first done of each DUT
    task automatic step();
        logic [2:0] d, g, l, e;
        @(posedge clk);
        #1;
        cyc++;
        d = {bus_f.done, bus_s.done, bus_u.done};
        g = {bus_f.greater, bus_s.greater, bus_u.greater};
        l = {bus_f.less, bus_s.less, bus_u.less};
        e = {bus_f.equal, bus_s.equal, bus_u.equal};
        for (int i = 0; i < 3; i++) begin
            if (d[i]) begin
                cnt[i]++;
                if (lat[i] == 0) begin
                    lat[i] = cyc;
                    res[i] = {g[i], l[i], e[i]};
                end
            end
        end
    endtask

    // lat counts edges after the acceptance edge until done is seen
    task automatic run_cmp(input logic [7:0] aa, input logic [7:0] bb, input int restart_at);
        @(negedge clk);
        a     = aa;
        b     = bb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~aa;
        b     = ~bb;
        clear_obs();
        for (int i = 1; i <= 20; i++) begin
            if (i == restart_at) start = 1'b1;
            step();
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [4:0] o [3];
        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        o[0] = {bus_u.busy, bus_u.done, bus_u.greater, bus_u.less, bus_u.equal};
        o[1] = {bus_s.busy, bus_s.done, bus_s.greater, bus_s.less, bus_s.equal};
        o[2] = {bus_f.busy, bus_f.done, bus_f.greater, bus_f.less, bus_f.equal};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o[i] !== 5'b00000) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %b expected 00000", i, o[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_compare_vectors();
        vec_t vt [7];
        vt[0] = '{a: 8'h80, b: 8'h7F, lat: '{1, 1, 8}, res: '{R_GT, R_LT, R_GT}};
        vt[1] = '{a: 8'hFF, b: 8'hFE, lat: '{8, 8, 8}, res: '{R_GT, R_GT, R_GT}};
        vt[2] = '{a: 8'h3C, b: 8'h3C, lat: '{8, 8, 8}, res: '{R_EQ, R_EQ, R_EQ}};
        vt[3] = '{a: 8'hA5, b: 8'hA4, lat: '{8, 8, 8}, res: '{R_GT, R_GT, R_GT}};
        vt[4] = '{a: 8'h80, b: 8'h00, lat: '{1, 1, 8}, res: '{R_GT, R_LT, R_GT}};
        vt[5] = '{a: 8'h01, b: 8'h02, lat: '{7, 7, 8}, res: '{R_LT, R_LT, R_LT}};
        vt[6] = '{a: 8'h40, b: 8'h80, lat: '{1, 1, 8}, res: '{R_LT, R_GT, R_LT}};
        for (int v = 0; v < 7; v++) begin
            run_cmp(vt[v].a, vt[v].b, 0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (lat[i] !== vt[v].lat[i]) begin
                    errors++;
                    $display("FAIL vec%0d_latency dut%0d: got %0d expected %0d", v, i, lat[i], vt[v].lat[i]);
                end
                checks++;
                if (res[i] !== vt[v].res[i]) begin
                    errors++;
                    $display("FAIL vec%0d_result dut%0d: got gt/lt/eq %b expected %b", v, i, res[i], vt[v].res[i]);
                end
                checks++;
                if (cnt[i] !== 1) begin
                    errors++;
                    $display("FAIL vec%0d_done_count dut%0d: got %0d expected 1", v, i, cnt[i]);
                end
            end
        end
    endtask

    task automatic test_busy_ignore();
        run_cmp(8'h3C, 8'h3C, 3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cnt[i] !== 1 || lat[i] !== 8 || res[i] !== R_EQ) begin
                errors++;
                $display("FAIL busy_ignore dut%0d: got count %0d lat %0d res %b expected 1 8 %b",
                         i, cnt[i], lat[i], res[i], R_EQ);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic       found;
        logic [4:0] o [3];
        int         exp_lat [3];
        exp_lat = '{7, 7, 8};
        @(negedge clk);
        a     = 8'hA5;
        b     = 8'hA4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear_obs();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bus_f.done) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_done: got none expected done within 20 cycles");
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (lat[i] !== 8 || res[i] !== R_GT) begin
                errors++;
                $display("FAIL b2b_first dut%0d: got lat %0d res %b expected 8 %b", i, lat[i], res[i], R_GT);
            end
        end
        // start on the done cycle must be taken immediately
        a     = 8'h01;
        b     = 8'h02;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        o[0] = {bus_u.busy, bus_u.done, bus_u.greater, bus_u.less, bus_u.equal};
        o[1] = {bus_s.busy, bus_s.done, bus_s.greater, bus_s.less, bus_s.equal};
        o[2] = {bus_f.busy, bus_f.done, bus_f.greater, bus_f.less, bus_f.equal};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o[i] !== 5'b10000) begin
                errors++;
                $display("FAIL b2b_accept dut%0d: got busy/done/gt/lt/eq %b expected 10000", i, o[i]);
            end
        end
        clear_obs();
        repeat (20) step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (lat[i] !== exp_lat[i] || res[i] !== R_LT || cnt[i] !== 1) begin
                errors++;
                $display("FAIL b2b_second dut%0d: got lat %0d res %b count %0d expected %0d %b 1",
                         i, lat[i], res[i], cnt[i], exp_lat[i], R_LT);
            end
        end
    endtask

    task automatic test_continuous();
        int exp_cnt [3];
        exp_cnt = '{5, 5, 1};
        @(negedge clk);
        a     = 8'h80;
        b     = 8'h7F;
        start = 1'b1;
        clear_obs();
        repeat (10) step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cnt[i] !== exp_cnt[i]) begin
                errors++;
                $display("FAIL continuous_count dut%0d: got %0d expected %0d", i, cnt[i], exp_cnt[i]);
            end
        end
        repeat (12) step();
        exp_cnt = '{5, 5, 2};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cnt[i] !== exp_cnt[i]) begin
                errors++;
                $display("FAIL continuous_drain dut%0d: got %0d expected %0d", i, cnt[i], exp_cnt[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] o [3];
        int         exp_lat [3];
        logic [2:0] exp_res [3];
        exp_lat = '{1, 1, 8};
        exp_res = '{R_GT, R_LT, R_GT};
        @(negedge clk);
        a     = 8'h3C;
        b     = 8'h3C;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear_obs();
        repeat (3) step();
        o[0] = {bus_u.busy, bus_u.done, bus_u.greater, bus_u.less, bus_u.equal};
        o[1] = {bus_s.busy, bus_s.done, bus_s.greater, bus_s.less, bus_s.equal};
        o[2] = {bus_f.busy, bus_f.done, bus_f.greater, bus_f.less, bus_f.equal};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o[i] !== 5'b10000) begin
                errors++;
                $display("FAIL mid_busy dut%0d: got %b expected 10000", i, o[i]);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        o[0] = {bus_u.busy, bus_u.done, bus_u.greater, bus_u.less, bus_u.equal};
        o[1] = {bus_s.busy, bus_s.done, bus_s.greater, bus_s.less, bus_s.equal};
        o[2] = {bus_f.busy, bus_f.done, bus_f.greater, bus_f.less, bus_f.equal};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o[i] !== 5'b00000) begin
                errors++;
                $display("FAIL mid_reset dut%0d: got %b expected 00000", i, o[i]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        repeat (12) step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cnt[i] !== 0) begin
                errors++;
                $display("FAIL mid_no_done dut%0d: got %0d dones expected 0", i, cnt[i]);
            end
        end
        run_cmp(8'h80, 8'h7F, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (lat[i] !== exp_lat[i] || res[i] !== exp_res[i]) begin
                errors++;
                $display("FAIL mid_restart dut%0d: got lat %0d res %b expected %0d %b",
                         i, lat[i], res[i], exp_lat[i], exp_res[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_compare_vectors();
        test_busy_ignore();
        test_back_to_back();
        test_continuous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
